// File: rtl/adc_rx_pkg.sv
// Shared types and frame geometry for the multi-channel ADC serial receiver.
package adc_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    QUIET = 2'd2
  } state_t;

  // Total SCLK periods per frame: leading zeros followed by data bits.
  function automatic int frame_w(input int zero_w, input int data_w);
    return zero_w + data_w;
  endfunction

endpackage

// File: rtl/adc_sclk_en.sv
// SCLK generator: free-running divider producing a clock-enable style toggle.
// SCLK is an ordinary register output; nothing downstream is clocked by it.
// 'rise' is high for the single clk cycle in which SCLK has just gone high.
module adc_sclk_en #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic sclk,
  output logic rise
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = (cnt == CW'(CLK_DIV - 1));

  // Half-period counter; SCLK toggles on terminal count, clear parks it high.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      sclk <= 1'b1;
      rise <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (tick) begin
        cnt  <= '0;
        sclk <= ~sclk;
        rise <= ~sclk;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_serial_rx_multi.sv
// Multi-channel serial ADC receiver: drives CS/SCLK, shifts N_CH data lines
// in parallel, and publishes each completed frame with a one-cycle rx_listo.
// Optional leading-zero check enabled by defining ADC_RX_ZERO_CHECK_EN.
//
// state | meaning
// IDLE  | CS high, waiting for inicio_rx
// CONV  | CS low, SCLK running, sampling dato on each SCLK rise
// QUIET | CS high for QUIET_CYC SCLK periods before next frame or IDLE
module adc_serial_rx_multi
  import adc_rx_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int ZERO_W    = 4,
  parameter int N_CH      = 2,
  parameter int CLK_DIV   = 4,
  parameter int QUIET_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inicio_rx,
  input  logic                     modo_continuo,
  input  logic [N_CH-1:0]          dato,
  output logic                     CS,
  output logic                     SCLK,
  output logic                     rx_listo,
  output logic [N_CH*DATA_W-1:0]   paquete_bits,
  output logic [N_CH*ZERO_W-1:0]   bits_zero,
  output logic                     error_cero
);

  localparam int FRAME_W   = frame_w(ZERO_W, DATA_W);
  localparam int QUIET_LEN = QUIET_CYC * 2 * CLK_DIV;
  localparam int BW        = $clog2(FRAME_W);
  localparam int QW        = $clog2(QUIET_LEN);

  state_t               state_q, state_d;
  logic                 rise;
  logic [BW-1:0]        bit_cnt;
  logic [QW-1:0]        quiet_cnt;
  logic                 frame_done;
  logic                 quiet_done;
  logic [FRAME_W-1:0]   shreg [N_CH];
  logic [FRAME_W-1:0]   word  [N_CH];

  adc_sclk_en #(.CLK_DIV(CLK_DIV)) u_sclk_en (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != CONV),
    .sclk (SCLK),
    .rise (rise)
  );

  assign CS         = (state_q != CONV);
  assign frame_done = (state_q == CONV) && rise && (bit_cnt == '0);
  assign quiet_done = (state_q == QUIET) && (quiet_cnt == '0);

  // Shift register contents including the bit being sampled this cycle.
  for (genvar g = 0; g < N_CH; g++) begin : g_word
    assign word[g] = {shreg[g][FRAME_W-2:0], dato[g]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; inicio_rx only matters in IDLE, modo_continuo only at end of QUIET.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (inicio_rx)  state_d = CONV;
      CONV:    if (frame_done) state_d = QUIET;
      QUIET:   if (quiet_done) state_d = modo_continuo ? CONV : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit/quiet down-counters, sampling shift registers and frame publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt      <= BW'(FRAME_W - 1);
      quiet_cnt    <= QW'(QUIET_LEN - 1);
      rx_listo     <= 1'b0;
      paquete_bits <= '0;
      bits_zero    <= '0;
      for (int i = 0; i < N_CH; i++) shreg[i] <= '0;
    end else begin
      rx_listo <= frame_done;

      if (state_q != CONV)  bit_cnt <= BW'(FRAME_W - 1);
      else if (rise)        bit_cnt <= bit_cnt - 1'b1;

      if (state_q != QUIET) quiet_cnt <= QW'(QUIET_LEN - 1);
      else                  quiet_cnt <= quiet_cnt - 1'b1;

      if ((state_q == CONV) && rise) begin
        for (int i = 0; i < N_CH; i++) shreg[i] <= word[i];
      end

      if (frame_done) begin
        for (int i = 0; i < N_CH; i++) begin
          paquete_bits[i*DATA_W +: DATA_W] <= word[i][DATA_W-1:0];
          bits_zero[i*ZERO_W +: ZERO_W]    <= word[i][FRAME_W-1 -: ZERO_W];
        end
      end
    end
  end

`ifdef ADC_RX_ZERO_CHECK_EN
  logic any_zero;

  // Any channel whose leading bits of the completing frame are not all zero.
  always_comb begin
    any_zero = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      any_zero = any_zero | (|word[i][FRAME_W-1 -: ZERO_W]);
    end
  end

  // Zero-check flag, refreshed together with the frame outputs.
  always_ff @(posedge clk) begin
    if (rst)             error_cero <= 1'b0;
    else if (frame_done) error_cero <= any_zero;
  end
`else
  assign error_cero = 1'b0;
`endif

endmodule

// File: tb/tb_adc_serial_rx_multi.sv
// Self-checking bench for adc_serial_rx_multi with default parameters.
module tb_adc_serial_rx_multi;

  localparam int DATA_W    = 12;
  localparam int ZERO_W    = 4;
  localparam int N_CH      = 2;
  localparam int CLK_DIV   = 4;
  localparam int QUIET_CYC = 2;
  localparam int FRAME_W   = ZERO_W + DATA_W;
  localparam int CONV_LEN  = FRAME_W * 2 * CLK_DIV;
  localparam int QUIET_LEN = QUIET_CYC * 2 * CLK_DIV;
`ifdef ADC_RX_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   inicio_rx = 1'b0;
  logic                   modo_continuo = 1'b0;
  logic [N_CH-1:0]        dato = '0;
  logic                   CS, SCLK, rx_listo, error_cero;
  logic [N_CH*DATA_W-1:0] paquete_bits;
  logic [N_CH*ZERO_W-1:0] bits_zero;

  adc_serial_rx_multi #(
    .DATA_W(DATA_W), .ZERO_W(ZERO_W), .N_CH(N_CH),
    .CLK_DIV(CLK_DIV), .QUIET_CYC(QUIET_CYC)
  ) dut (
    .clk(clk), .rst(rst), .inicio_rx(inicio_rx), .modo_continuo(modo_continuo),
    .dato(dato), .CS(CS), .SCLK(SCLK), .rx_listo(rx_listo),
    .paquete_bits(paquete_bits), .bits_zero(bits_zero), .error_cero(error_cero)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;

  // Model state: phase 0 idle, 1 converting, 2 quiet; m_t = cycles spent in phase.
  int                     m_phase = 0;
  int                     m_t = 0;
  logic [FRAME_W-1:0]     m_tx [N_CH];
  logic [N_CH*DATA_W-1:0] m_paq = '0;
  logic [N_CH*ZERO_W-1:0] m_zero = '0;
  logic                   m_err = 1'b0;
  logic                   m_listo = 1'b0;
  bit                     chk_en = 1'b0;

  int   listo_q[$];
  int   fall_q[$];
  logic cs_prev = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timeline model: a frame is CONV_LEN+1 cycles of CS low, then a QUIET_LEN gap.
  always @(posedge clk) begin
    cyc++;
    m_listo = 1'b0;
    if (rst) begin
      m_phase = 0; m_t = 0; m_paq = '0; m_zero = '0; m_err = 1'b0;
    end else begin
      case (m_phase)
        0: if (inicio_rx) begin m_phase = 1; m_t = 0; end
        1: if (m_t == CONV_LEN) begin
             m_phase = 2; m_t = 0; m_listo = 1'b1;
             for (int c = 0; c < N_CH; c++) begin
               m_paq[c*DATA_W +: DATA_W]  = m_tx[c][DATA_W-1:0];
               m_zero[c*ZERO_W +: ZERO_W] = m_tx[c][FRAME_W-1 -: ZERO_W];
             end
             m_err = ZC && (m_zero != '0);
           end else m_t++;
        default: if (m_t == QUIET_LEN - 1) begin
             m_phase = modo_continuo ? 1 : 0; m_t = 0;
           end else m_t++;
      endcase
    end
  end

  // Serial ADC behaviour: bit k is valid from the k-th SCLK rise until the next.
  always @(negedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (m_phase == 1 && m_t >= 2*CLK_DIV) begin
        int idx;
        idx = m_t / (2*CLK_DIV) - 1;
        dato[c] = m_tx[c][FRAME_W-1-idx];
      end else begin
        dato[c] = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, plus event logging.
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("cs",       CS,           (m_phase != 1));
      chk("sclk",     SCLK,         (m_phase == 1) ? (((m_t / CLK_DIV) % 2) == 0) : 1'b1);
      chk("rx_listo", rx_listo,     m_listo);
      chk("paquete",  paquete_bits, m_paq);
      chk("zero",     bits_zero,    m_zero);
      chk("err",      error_cero,   m_err);
    end
    if (rx_listo === 1'b1) listo_q.push_back(cyc);
    if (cs_prev === 1'b1 && CS === 1'b0) fall_q.push_back(cyc);
    cs_prev = CS;
  end

  task automatic start_frame(output int c0);
    inicio_rx = 1'b1;
    c0 = cyc;
    @(negedge clk);
    inicio_rx = 1'b0;
  endtask

  task automatic wait_listo(input int n, input int bound);
    int k;
    k = 0;
    while (listo_q.size() < n && k < bound) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (listo_q.size() < n) begin
      n_err++;
      $display("FAIL wait_listo: got %0d pulses expected %0d within %0d cycles", listo_q.size(), n, bound);
    end
  endtask

  initial begin
    int c0;
    m_tx[0] = 16'h0ABC;
    m_tx[1] = 16'h0123;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_cs", CS, 1'b1);
    chk("rst_sclk", SCLK, 1'b1);
    chk("rst_paq", paquete_bits, '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame, basic timing and data.
    listo_q.delete(); fall_q.delete();
    start_frame(c0);
    wait_listo(1, 300);
    if (listo_q.size() >= 1) chk("a_listo_cycle", listo_q[0] - c0, 130);
    if (fall_q.size() >= 1)  chk("a_cs_fall", fall_q[0] - c0, 1);
    chk("a_paq", paquete_bits, 24'h123ABC);
    chk("a_zero", bits_zero, 8'h00);
    chk("a_err", error_cero, 1'b0);
    repeat (20) @(negedge clk);

    // Nonzero leading bits on channel 0.
    m_tx[0] = 16'h8FFF;
    listo_q.delete(); fall_q.delete();
    start_frame(c0);
    wait_listo(1, 300);
    chk("b_paq0", paquete_bits[11:0], 12'hFFF);
    chk("b_zero0", bits_zero[3:0], 4'h8);
    chk("b_err", error_cero, ZC);
    repeat (20) @(negedge clk);

    // Continuous mode for three frames, dropped during the third.
    m_tx[0] = 16'h0C3A;
    m_tx[1] = 16'h0A5C;
    listo_q.delete(); fall_q.delete();
    modo_continuo = 1'b1;
    start_frame(c0);
    wait_listo(2, 600);
    repeat (50) @(negedge clk);
    modo_continuo = 1'b0;
    wait_listo(3, 300);
    repeat (200) @(negedge clk);
    if (listo_q.size() >= 3) begin
      chk("c_period1", listo_q[1] - listo_q[0], 145);
      chk("c_period2", listo_q[2] - listo_q[1], 145);
    end
    if (listo_q.size() >= 2 && fall_q.size() >= 3) begin
      chk("c_gap1", fall_q[1] - listo_q[0], 16);
      chk("c_gap2", fall_q[2] - listo_q[1], 16);
    end
    chk("c_pulses", listo_q.size(), 3);
    chk("c_frames", fall_q.size(), 3);
    chk("c_paq", paquete_bits, 24'hA5CC3A);

    // Reset in the middle of a frame.
    m_tx[0] = 16'h0ABC;
    m_tx[1] = 16'h0123;
    listo_q.delete(); fall_q.delete();
    start_frame(c0);
    repeat (59) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("d_cs", CS, 1'b1);
    chk("d_sclk", SCLK, 1'b1);
    chk("d_paq", paquete_bits, '0);
    chk("d_zero", bits_zero, '0);
    chk("d_listo", rx_listo, 1'b0);
    repeat (150) @(negedge clk);
    chk("d_no_listo", listo_q.size(), 0);
    start_frame(c0);
    wait_listo(1, 300);
    if (listo_q.size() >= 1) chk("d_listo_cycle", listo_q[0] - c0, 130);
    chk("d_paq_after", paquete_bits, 24'h123ABC);
    repeat (20) @(negedge clk);

    // inicio_rx held through a frame without continuous mode.
    listo_q.delete(); fall_q.delete();
    inicio_rx = 1'b1;
    c0 = cyc;
    wait_listo(1, 300);
    begin
      int k;
      k = 0;
      while (fall_q.size() < 2 && k < 100) begin @(negedge clk); k++; end
    end
    inicio_rx = 1'b0;
    if (listo_q.size() >= 1) chk("e_listo_cycle", listo_q[0] - c0, 130);
    chk("e_restarts", fall_q.size(), 2);
    if (fall_q.size() >= 2) chk("e_restart_cycle", fall_q[1] - c0, 147);
    wait_listo(2, 300);
    repeat (40) @(negedge clk);
    chk("e_pulses", listo_q.size(), 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
